// File: rtl/iob_axi_ram_rd_arb_pkg.sv
// Shared types for the AXI RAM read arbiter: FSM encoding and ID width.
package iob_axi_ram_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Rotate-priority encoder: first set valid bit at or after ptr_i,
// wrapping, as one-hot grant and binary index.
module iob_rr_prio_enc #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] kk;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    kk    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      kk = IDX_W'((int'(ptr_i) + i) % N_REQ);
      if (!any_o && valid_i[kk]) begin
        any_o     = 1'b1;
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
  end

endmodule

// File: rtl/iob_axi_ram_rd_arb.sv
// N-requester read arbiter in front of one AXI RAM, one burst at a time.
// IOB_AXI_RAM_RD_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins).
module iob_axi_ram_rd_arb
  import iob_axi_ram_rd_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*LEN_W-1:0]    req_len_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  input  logic [N_REQ-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_last_o,
  output logic [id_w(N_REQ)-1:0]    axi_arid_o,
  output logic [ADDR_W-1:0]         axi_araddr_o,
  output logic [LEN_W-1:0]          axi_arlen_o,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  input  logic [DATA_W-1:0]         axi_rdata_i,
  input  logic                      axi_rlast_i,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o
);

  localparam int ID_W = id_w(N_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [N_REQ-1:0]  rdy_q, rdy_d;

  logic [N_REQ-1:0]  enc_gnt;
  logic [ID_W-1:0]   enc_idx;
  logic              enc_any;
  logic              in_data;
  logic              rdy_g;
  logic              fire;
  logic [ID_W-1:0]   nxt_ptr;

  iob_rr_prio_enc #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_enc (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (enc_gnt),
    .idx_o   (enc_idx),
    .any_o   (enc_any)
  );

  assign in_data = (state_q == ST_DATA);

  // R channel is a straight wire to the granted requester while in DATA
  always_comb begin
    rdy_g       = 1'b0;
    rsp_valid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gid_q == ID_W'(k)) begin
        rdy_g          = rsp_ready_i[k];
        rsp_valid_o[k] = in_data & axi_rvalid_i;
      end
    end
  end

  assign axi_rready_o  = in_data & rdy_g;
  assign rsp_data_o    = axi_rdata_i;
  assign rsp_last_o    = in_data & axi_rlast_i;
  assign fire          = axi_rvalid_i & axi_rready_o;

  assign axi_arvalid_o = (state_q == ST_ADDR);
  assign axi_arid_o    = gid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = len_q;
  assign req_ready_o   = rdy_q;

`ifdef IOB_AXI_RAM_RD_ARB_FIXED_PRIO_EN
  assign nxt_ptr = '0;
`else
  assign nxt_ptr = (gid_q == ID_W'(N_REQ - 1)) ?
                   '0 : gid_q + ID_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rdy_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          gid_d   = enc_idx;
          rdy_d   = enc_gnt;
          state_d = ST_ADDR;
          for (int k = 0; k < N_REQ; k++) begin
            if (enc_gnt[k]) begin
              addr_d = req_addr_i[k*ADDR_W +: ADDR_W];
              len_d  = req_len_i[k*LEN_W +: LEN_W];
            end
          end
        end
      end
      ST_ADDR: begin
        if (axi_arready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fire && axi_rlast_i) begin
          state_d = ST_IDLE;
          ptr_d   = nxt_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: doc/iob_axi_ram_rd_arb.md
IOB_AXI_RAM_RD_ARB -- requirements
Module: iob_axi_ram_rd_arb

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 16: byte address width.
REQ-003 Parameter DATA_W, default 32: AXI data width.
REQ-004 Parameter LEN_W, default 8: AXI burst length field width.
REQ-005 Port clk_i, input, 1: single clock, all logic on rising edge.
REQ-006 Port arst_n_i, input, 1: reset, asynchronous, active-low.
REQ-007 Port req_valid_i, input, N_REQ: per-requester burst request.
REQ-008 Port req_ready_o, output, N_REQ: one-cycle grant/accept pulse.
REQ-009 Port req_addr_i, input, N_REQ*ADDR_W: packed start byte addresses, requester k in slice k.
REQ-010 Port req_len_i, input, N_REQ*LEN_W: packed burst lengths minus one.
REQ-011 Port rsp_valid_o, output, N_REQ: read beat valid, granted requester only.
REQ-012 Port rsp_ready_i, input, N_REQ: per-requester beat ready.
REQ-013 Port rsp_data_o, output, DATA_W: shared read data.
REQ-014 Port rsp_last_o, output, 1: shared last-beat flag.
REQ-015 Ports axi_arid_o (ID_W=clog2(N_REQ)), axi_araddr_o (ADDR_W), axi_arlen_o (LEN_W), axi_arvalid_o (1): outputs; AR channel to the RAM.
REQ-016 Port axi_arready_i, input, 1: AR channel ready.
REQ-017 Ports axi_rdata_i (DATA_W), axi_rlast_i (1), axi_rvalid_i (1): inputs; R channel from the RAM.
REQ-018 Port axi_rready_o, output, 1: R channel ready.

Function
REQ-019 FSM states: IDLE, ADDR, DATA; at most one burst outstanding.
REQ-020 IDLE with any req_valid_i bit set: grant g = first set bit at or after priority pointer, wrapping modulo N_REQ; register g, araddr, arlen, and arid=g; next state ADDR.
REQ-021 req_ready_o[g] is high for exactly the one cycle following the grant decision; requesters hold valid/addr/len stable until that cycle.
REQ-022 ADDR: axi_arvalid_o=1 and AR fields stable; on axi_arready_i go to DATA, arvalid low next cycle.
REQ-023 DATA: combinational pass-through: rsp_valid_o[g]=axi_rvalid_i, all other bits 0; axi_rready_o=rsp_ready_i[g]; rsp_data_o=axi_rdata_i; rsp_last_o=axi_rlast_i.
REQ-024 DATA exits to IDLE on axi_rvalid_i & axi_rready_o & axi_rlast_i; priority pointer becomes (g+1) mod N_REQ.
REQ-025 Minimum gap: one IDLE cycle between consecutive bursts; back-to-back requests from the same requester are legal.
REQ-026 Outside DATA: rsp_valid_o=0 and axi_rready_o=0; R beats are never dropped or reordered.
REQ-027 axi_rid_i is not consumed; ID correctness is a verification check only.

Reset
REQ-028 Asserted reset: state IDLE, pointer 0, req_ready_o=0, axi_arvalid_o=0, AR fields 0, rsp_valid_o=0, axi_rready_o=0.
REQ-029 Reset mid-burst abandons the burst; the RAM shares the same reset.

Configuration
REQ-030 Macro IOB_AXI_RAM_RD_ARB_FIXED_PRIO_EN defined: pointer fixed at 0, lowest index wins; undefined: round-robin per REQ-020/024.

Structure
REQ-031 Package iob_axi_ram_rd_arb_pkg holds the FSM state encoding and the ID_W computation.
REQ-032 Sub-module iob_rr_prio_enc: N_REQ-wide rotate-priority encoder (valid vector, pointer -> one-hot grant + index).

Verification
REQ-033 Single req0, addr 0x10, len 3 -> araddr 0x10, arlen 3, arid 0; 4 beats to req0; rsp_last_o on beat 4.
REQ-034 req0 and req1 both held valid -> grants alternate 0,1,0,1 (round-robin); with macro defined -> 0,0,0.
REQ-035 rsp_ready_i[g] low for 5 cycles mid-burst -> axi_rready_o low, no beat lost, data order intact.
REQ-036 axi_arready_i delayed 3 cycles -> axi_arvalid_o held with fields stable; req_ready_o pulses once only.
REQ-037 arst_n_i low during beat 2 of len 7 -> all outputs at reset values the same cycle; next request served normally.
REQ-038 len 0 from requester N_REQ-1 -> single beat with rsp_last_o=1; pointer wraps to 0.
